comb_dbus_dmem_ctrl: RTL and testbench

Shared data-memory controller for the multicore CFU Proving Ground. It sits between the per-core data-bus address decoders and one single-port word memory. Each cycle it grants one core's request through a combinational round-robin arbiter and stalls the rest. It also implements RISC-V LR/SC reservations so harts can build atomics.

---
 rtl/comb_dbus_dmem_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_comb_dbus_dmem_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/comb_dbus_dmem_ctrl.sv
// Shared single-port data memory with a combinational round-robin arbiter and LR/SC reservations.
// Optional feature macro: CDMEM_LRSC_EN (defined = LR/SC reservations tracked; undefined = SC always succeeds).
module comb_dbus_dmem_ctrl #(
  parameter int NCORES     = 2,
  parameter int DMEM_ADDRW = 12
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NCORES-1:0]              re_packed_i,
  input  logic [NCORES-1:0]              we_packed_i,
  input  logic [DMEM_ADDRW*NCORES-1:0]   addr_packed_i,
  input  logic [32*NCORES-1:0]           wdata_packed_i,
  input  logic [4*NCORES-1:0]            wstrb_packed_i,
  input  logic [NCORES-1:0]              is_lr_packed_i,
  input  logic [NCORES-1:0]              is_sc_packed_i,
  output logic [32*NCORES-1:0]           rdata_packed_o,
  output logic [NCORES-1:0]              stall_packed_o
);

  localparam int PTRW  = (NCORES > 1) ? $clog2(NCORES) : 1;
  localparam int DEPTH = 1 << DMEM_ADDRW;

  logic [DMEM_ADDRW-1:0] addr  [NCORES];
  logic [31:0]           wdata [NCORES];
  logic [3:0]            wstrb [NCORES];

  for (genvar k = 0; k < NCORES; k++) begin : g_unpack
    assign addr[k]  = addr_packed_i[DMEM_ADDRW*k +: DMEM_ADDRW];
    assign wdata[k] = wdata_packed_i[32*k +: 32];
    assign wstrb[k] = wstrb_packed_i[4*k +: 4];
  end

  // ---------------------------------------------------------------------------
  // Round-robin arbiter
  // ---------------------------------------------------------------------------
  logic [NCORES-1:0] req;
  logic [NCORES-1:0] grant;
  logic              gnt_valid;
  logic [PTRW-1:0]   gnt_idx;
  logic [PTRW-1:0]   p_q, p_d;

  assign req = re_packed_i | we_packed_i;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned (which would infer a latch); combinational code uses blocking '='.
  always_comb begin
    int              c;
    logic [PTRW-1:0] cand;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    grant     = '0;
    c         = 0;
    cand      = '0;
    for (int i = 0; i < NCORES; i++) begin
      c = int'(p_q) + i;
      if (c >= NCORES) c = c - NCORES;
      cand = PTRW'(c);
      if (!gnt_valid && req[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
    if (gnt_valid) grant[gnt_idx] = 1'b1;
  end

  assign stall_packed_o = req & ~grant;

  always_comb begin
    p_d = p_q;
    if (gnt_valid) begin
      p_d = (int'(gnt_idx) == NCORES - 1) ? '0 : gnt_idx + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop samples the
  // pre-edge value of its neighbours.
  always_ff @(posedge clk_i) begin
    if (rst_i) p_q <= '0;
    else       p_q <= p_d;
  end

  // ---------------------------------------------------------------------------
  // Granted access decode
  // ---------------------------------------------------------------------------
  logic [DMEM_ADDRW-1:0] g_addr;
  logic [31:0]           g_wdata;
  logic [3:0]            g_wstrb;
  logic                  g_we, g_rd, g_sc;
  logic                  sc_ok;
  logic                  do_write;

  assign g_addr   = addr[gnt_idx];
  assign g_wdata  = wdata[gnt_idx];
  assign g_wstrb  = wstrb[gnt_idx];
  assign g_we     = gnt_valid & we_packed_i[gnt_idx];
  assign g_rd     = gnt_valid & re_packed_i[gnt_idx] & ~we_packed_i[gnt_idx];
  assign g_sc     = g_we & is_sc_packed_i[gnt_idx];
  // A failed SC and anything presented during reset must leave memory untouched.
  assign do_write = g_we & (~g_sc | sc_ok) & ~rst_i;

`ifdef CDMEM_LRSC_EN
  logic              g_lr;
  logic [NCORES-1:0] sc_hit;
  assign g_lr  = g_rd & is_lr_packed_i[gnt_idx];
  assign sc_ok = sc_hit[gnt_idx];
`else
  logic unused_lr;
  assign unused_lr = ^is_lr_packed_i;
  assign sc_ok     = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // Word memory
  // ---------------------------------------------------------------------------
  logic [31:0] mem [DEPTH];
  logic [31:0] mem_rd;
  logic [31:0] wmask;
  logic [31:0] wmerge;

  assign mem_rd = mem[g_addr];
  assign wmask  = {{8{g_wstrb[3]}}, {8{g_wstrb[2]}}, {8{g_wstrb[1]}}, {8{g_wstrb[0]}}};
  assign wmerge = (mem_rd & ~wmask) | (g_wdata & wmask);

  // NOTE: the memory array has no reset branch; clearing thousands of words is
  // not part of the contract and would prevent mapping onto a RAM macro.
  always_ff @(posedge clk_i) begin
    if (do_write) mem[g_addr] <= wmerge;
  end

  // ---------------------------------------------------------------------------
  // Per-core result registers and reservations
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < NCORES; k++) begin : g_core
    logic        sel;
    logic [31:0] rdata_q, rdata_d;

    assign sel = gnt_valid && (gnt_idx == PTRW'(k));

    always_comb begin
      rdata_d = rdata_q;
      if (sel && g_rd)      rdata_d = mem_rd;
      else if (sel && g_sc) rdata_d = sc_ok ? 32'd0 : 32'd1;
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) rdata_q <= '0;
      else       rdata_q <= rdata_d;
    end

    assign rdata_packed_o[32*k +: 32] = rdata_q;

`ifdef CDMEM_LRSC_EN
    logic                  resv_valid_q, resv_valid_d;
    logic [DMEM_ADDRW-1:0] resv_addr_q, resv_addr_d;

    assign sc_hit[k] = resv_valid_q && (resv_addr_q == g_addr);

    always_comb begin
      resv_valid_d = resv_valid_q;
      resv_addr_d  = resv_addr_q;
      // Another core's store to the reserved word breaks this reservation.
      if (do_write && !sel && sc_hit[k]) resv_valid_d = 1'b0;
      if (sel && g_sc) resv_valid_d = 1'b0;
      if (sel && g_lr) begin
        resv_valid_d = 1'b1;
        resv_addr_d  = g_addr;
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        resv_valid_q <= 1'b0;
        resv_addr_q  <= '0;
      end else begin
        resv_valid_q <= resv_valid_d;
        resv_addr_q  <= resv_addr_d;
      end
    end
`endif
  end

endmodule

// File: tb/tb_comb_dbus_dmem_ctrl.sv
// Self-checking bench for comb_dbus_dmem_ctrl (NCORES=2): directed plan followed by random
// traffic, compared against a behavioural model of memory, reservations and the round-robin pointer.
module tb_comb_dbus_dmem_ctrl;

  localparam int NC = 2;
  localparam int AW = 12;
`ifdef CDMEM_LRSC_EN
  localparam bit LRSC = 1'b1;
`else
  localparam bit LRSC = 1'b0;
`endif

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [NC-1:0]    re_packed_i, we_packed_i, is_lr_packed_i, is_sc_packed_i;
  logic [AW*NC-1:0] addr_packed_i;
  logic [32*NC-1:0] wdata_packed_i;
  logic [4*NC-1:0]  wstrb_packed_i;
  logic [32*NC-1:0] rdata_packed_o;
  logic [NC-1:0]    stall_packed_o;

  comb_dbus_dmem_ctrl #(.NCORES(NC), .DMEM_ADDRW(AW)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .re_packed_i    (re_packed_i),
    .we_packed_i    (we_packed_i),
    .addr_packed_i  (addr_packed_i),
    .wdata_packed_i (wdata_packed_i),
    .wstrb_packed_i (wstrb_packed_i),
    .is_lr_packed_i (is_lr_packed_i),
    .is_sc_packed_i (is_sc_packed_i),
    .rdata_packed_o (rdata_packed_o),
    .stall_packed_o (stall_packed_o)
  );

  always #5 clk_i = ~clk_i;

  // Per-core stimulus
  logic          re_v [NC];
  logic          we_v [NC];
  logic          lr_v [NC];
  logic          sc_v [NC];
  logic [AW-1:0] a_v  [NC];
  logic [31:0]   d_v  [NC];
  logic [3:0]    s_v  [NC];
  logic          held [NC];
  logic [NC-1:0] last_stall;

  // Reference model
  logic [31:0]   mem_m [1 << AW];
  logic          rv_m  [NC];
  logic [AW-1:0] ra_m  [NC];
  logic [31:0]   rd_m  [NC];
  int            ptr_m;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_core(input int k);
    re_v[k] = 1'b0; we_v[k] = 1'b0; lr_v[k] = 1'b0; sc_v[k] = 1'b0;
    a_v[k]  = '0;   d_v[k]  = '0;   s_v[k]  = '0;
  endtask

  task automatic set_wr(input int k, input logic [AW-1:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic sc);
    clear_core(k);
    we_v[k] = 1'b1; a_v[k] = a; d_v[k] = d; s_v[k] = s; sc_v[k] = sc;
  endtask

  task automatic set_rd(input int k, input logic [AW-1:0] a, input logic lr);
    clear_core(k);
    re_v[k] = 1'b1; a_v[k] = a; lr_v[k] = lr;
  endtask

  // One clock cycle: drive, check stall against the model's arbitration, advance the
  // model at the edge, then check both result registers.
  task automatic tick(input logic rst);
    logic [NC-1:0] req, gnt, sexp;
    logic [31:0]   mask;
    logic [AW-1:0] ga;
    logic          ok;
    int            g;
    rst_i          = rst;
    re_packed_i    = {re_v[1], re_v[0]};
    we_packed_i    = {we_v[1], we_v[0]};
    is_lr_packed_i = {lr_v[1], lr_v[0]};
    is_sc_packed_i = {sc_v[1], sc_v[0]};
    addr_packed_i  = {a_v[1], a_v[0]};
    wdata_packed_i = {d_v[1], d_v[0]};
    wstrb_packed_i = {s_v[1], s_v[0]};
    #1;
    req = {re_v[1] | we_v[1], re_v[0] | we_v[0]};
    g = -1;
    for (int i = 0; i < NC; i++) begin
      int c;
      c = (ptr_m + i) % NC;
      if (g < 0 && req[c]) g = c;
    end
    gnt = '0;
    if (g >= 0) gnt[g] = 1'b1;
    sexp = req & ~gnt;
    last_stall = stall_packed_o;
    chk("stall", 32'(stall_packed_o), 32'(sexp));
    held[0] = sexp[0];
    held[1] = sexp[1];
    @(posedge clk_i);
    if (rst) begin
      ptr_m = 0;
      for (int k = 0; k < NC; k++) begin rd_m[k] = '0; rv_m[k] = 1'b0; end
    end else if (g >= 0) begin
      ptr_m = (g + 1) % NC;
      ga    = a_v[g];
      if (we_v[g]) begin
        ok   = !(LRSC && sc_v[g]) || (rv_m[g] && ra_m[g] == ga);
        mask = {{8{s_v[g][3]}}, {8{s_v[g][2]}}, {8{s_v[g][1]}}, {8{s_v[g][0]}}};
        if (ok) begin
          mem_m[ga] = (mem_m[ga] & ~mask) | (d_v[g] & mask);
          for (int j = 0; j < NC; j++)
            if (j != g && rv_m[j] && ra_m[j] == ga) rv_m[j] = 1'b0;
        end
        if (sc_v[g]) begin
          rd_m[g] = ok ? 32'd0 : 32'd1;
          rv_m[g] = 1'b0;
        end
      end else begin
        rd_m[g] = mem_m[ga];
        if (LRSC && lr_v[g]) begin rv_m[g] = 1'b1; ra_m[g] = ga; end
      end
    end
    #1;
    chk("rdata0", rdata_packed_o[31:0],  rd_m[0]);
    chk("rdata1", rdata_packed_o[63:32], rd_m[1]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem_m[i] = '0;
    for (int k = 0; k < NC; k++) begin
      clear_core(k); rv_m[k] = 1'b0; ra_m[k] = '0; rd_m[k] = '0; held[k] = 1'b0;
    end
    ptr_m = 0;

    // Reset state
    tick(1'b1);
    tick(1'b1);
    chk("reset_stall", 32'(last_stall), 32'd0);

    // Single core write then read
    set_wr(0, 12'd5, 32'hDEADBEEF, 4'b1111, 1'b0);
    tick(1'b0);
    chk("wr_stall", 32'(last_stall), 32'd0);
    set_rd(0, 12'd5, 1'b0);
    tick(1'b0);
    chk("rd_stall", 32'(last_stall), 32'd0);
    chk("rd_deadbeef", rdata_packed_o[31:0], 32'hDEADBEEF);

    // Byte strobes
    set_wr(0, 12'd3, 32'h11223344, 4'b1111, 1'b0);
    tick(1'b0);
    set_wr(0, 12'd3, 32'hAABBCCDD, 4'b0101, 1'b0);
    tick(1'b0);
    set_rd(0, 12'd3, 1'b0);
    tick(1'b0);
    chk("byte_strobe", rdata_packed_o[31:0], 32'h11BB33DD);

    // Contention from reset: both cores request every cycle
    clear_core(0);
    tick(1'b1);
    set_rd(0, 12'd5, 1'b0);
    set_rd(1, 12'd3, 1'b0);
    tick(1'b0);
    chk("cont_first", 32'(last_stall), 32'b10);
    tick(1'b0);
    chk("cont_second", 32'(last_stall), 32'b01);
    chk("cont_rd0", rdata_packed_o[31:0],  32'hDEADBEEF);
    chk("cont_rd1", rdata_packed_o[63:32], 32'h11BB33DD);
    tick(1'b0);
    chk("cont_third", 32'(last_stall), 32'b10);
    tick(1'b0);
    chk("cont_fourth", 32'(last_stall), 32'b01);
    clear_core(1);

    // LR/SC success
    set_rd(0, 12'd8, 1'b1);
    tick(1'b0);
    set_wr(0, 12'd8, 32'h5, 4'b1111, 1'b1);
    tick(1'b0);
    chk("sc_ok_rdata", rdata_packed_o[31:0], 32'd0);
    set_rd(0, 12'd8, 1'b0);
    tick(1'b0);
    chk("sc_ok_mem", rdata_packed_o[31:0], 32'h5);

    // LR/SC broken by another core's store
    set_rd(0, 12'd8, 1'b1);
    tick(1'b0);
    clear_core(0);
    set_wr(1, 12'd8, 32'h77, 4'b1111, 1'b0);
    tick(1'b0);
    clear_core(1);
    set_wr(0, 12'd8, 32'h99, 4'b1111, 1'b1);
    tick(1'b0);
    chk("sc_broken", rdata_packed_o[31:0], LRSC ? 32'd1 : 32'd0);
    set_wr(0, 12'd8, 32'hAA, 4'b1111, 1'b1);
    tick(1'b0);
    chk("sc_second", rdata_packed_o[31:0], LRSC ? 32'd1 : 32'd0);
    set_rd(0, 12'd8, 1'b0);
    tick(1'b0);
    chk("sc_broken_mem", rdata_packed_o[31:0], LRSC ? 32'h77 : 32'hAA);

    // Reset between LR and SC; a write presented during reset is dropped
    set_rd(0, 12'd8, 1'b1);
    tick(1'b0);
    clear_core(0);
    set_wr(1, 12'd9, 32'hFFFF, 4'b1111, 1'b0);
    tick(1'b1);
    clear_core(1);
    set_wr(0, 12'd8, 32'h1234, 4'b1111, 1'b1);
    tick(1'b0);
    chk("sc_after_rst", rdata_packed_o[31:0], LRSC ? 32'd1 : 32'd0);
    set_rd(0, 12'd8, 1'b0);
    set_rd(1, 12'd9, 1'b0);
    tick(1'b0);
    tick(1'b0);
    chk("sc_after_rst_mem", rdata_packed_o[31:0], LRSC ? 32'h77 : 32'h1234);
    chk("rst_write_drop", rdata_packed_o[63:32], 32'd0);

    // Random traffic on a small address window; stalled cores hold their request
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < NC; k++) begin
        if (!held[k]) begin
          int op;
          op = $urandom_range(0, 5);
          clear_core(k);
          a_v[k] = 12'd8 + 12'($urandom_range(0, 3));
          d_v[k] = $urandom;
          s_v[k] = 4'($urandom_range(0, 15));
          case (op)
            1: re_v[k] = 1'b1;
            2: begin re_v[k] = 1'b1; lr_v[k] = 1'b1; end
            3: we_v[k] = 1'b1;
            4: begin we_v[k] = 1'b1; sc_v[k] = 1'b1; end
            5: begin re_v[k] = 1'b1; we_v[k] = 1'b1; lr_v[k] = 1'($urandom_range(0, 1)); end
            default: ;
          endcase
        end
      end
      tick($urandom_range(0, 49) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
